// File: rtl/bus_demux_regfile.sv
// bus_demux_regfile: steers one bus word into one of 16 registers via an IDLE/COMMIT handshake (bus_in/dest_sel/wr_valid in, wr_ready/busy/wr_count out, rd_sel -> rd_out combinational read)
module bus_demux_regfile #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] bus_in,
   input  logic [3:0]            dest_sel,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [3:0]            rd_sel,
   output logic [DATA_WIDTH-1:0] rd_out,
   output logic                  busy,
   output logic [7:0]            wr_count
);
   typedef enum logic {IDLE, COMMIT} state_t;
   state_t                state;
   logic [DATA_WIDTH-1:0] regs [16];
   logic [DATA_WIDTH-1:0] hold_data;
   logic [3:0]            hold_idx;
   always_ff @(posedge clock) begin
      if (clear) begin
         state     <= IDLE;
         wr_ready  <= 1'b1;
         busy      <= 1'b0;
         hold_data <= '0;
         hold_idx  <= '0;
         wr_count  <= '0;
         regs      <= '{default: '0};
      end else if (state == IDLE) begin
         if (wr_valid) begin
            hold_data <= bus_in;
            hold_idx  <= dest_sel;
            state     <= COMMIT;
            wr_ready  <= 1'b0;
            busy      <= 1'b1;
         end
      end else begin
         regs[hold_idx] <= hold_data;
         wr_count       <= wr_count + 8'd1;
         state          <= IDLE;
         wr_ready       <= 1'b1;
         busy           <= 1'b0;
      end
   end
   assign rd_out = regs[rd_sel];
endmodule
